// File: rtl/cmos_cfg_sequencer_pkg.sv
// cmos_cfg_pkg: shared types and constants for the CMOS sensor configuration sequencer.
// Revision 1.0
`default_nettype none

package cmos_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_DELAY    = 3'd4,
    S_NEXT     = 3'd5,
    S_DONE     = 3'd6,
    S_FAIL     = 3'd7
  } cfg_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_NACK     = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_EMPTY    = 2'd3;

  localparam logic [7:0] DEFAULT_DELAY_TAG = 8'hF0;

endpackage

`default_nettype wire

// File: rtl/cmos_cfg_sequencer_if.sv
// cmos_cfg_sequencer_if: command/response channel between sequencer and SCCB/I2C bus master.
// Revision 1.0
`default_nettype none

interface cmos_cfg_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_nack;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_nack, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_nack, rsp_rdata
  );
endinterface

`default_nettype wire

// File: rtl/cmos_cfg_sequencer_delay_timer.sv
// cfg_delay_timer: loadable down-counter with a zero flag; holds at zero.
// Revision 1.0
`default_nettype none

module cfg_delay_timer #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic [CNT_W-1:0] load_val_i,
  input  wire logic             en_i,
  output logic                  zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/cmos_cfg_sequencer.sv
// cmos_cfg_sequencer: walks a sensor config LUT, issuing read-verify, write and delay entries.
// Revision 1.0
`default_nettype none

module cmos_cfg_sequencer
  import cmos_cfg_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 16,
  parameter int                IDX_W      = 8,
  parameter int                READ_CNT   = 2,
  parameter logic [ADDR_W-1:0] DELAY_TAG  = ADDR_W'(DEFAULT_DELAY_TAG),
  parameter int                DELAY_UNIT = 1000,
  parameter int                MAX_RETRY  = 3
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     start_i,
  output logic [IDX_W-1:0]              lut_index_o,
  input  wire logic [ADDR_W+DATA_W-1:0] lut_data_i,
  input  wire logic [IDX_W-1:0]         lut_size_i,
  cmos_cfg_sequencer_if.master          bus,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o,
  output logic [1:0]                    err_code_o,
  output logic [IDX_W-1:0]              err_index_o
);

  // Counter wide enough for (2^DATA_W-1) * DELAY_UNIT.
  localparam int CNT_W   = DATA_W + ((DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 0);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0]   READ_LIMIT  = IDX_W'(READ_CNT);

  cfg_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  entry_q, entry_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [IDX_W-1:0]   err_index_q, err_index_d;

  logic [ADDR_W-1:0]  w_lut_addr;
  logic [DATA_W-1:0]  w_lut_data;
  logic               w_is_read;
  logic [CNT_W-1:0]   w_dly_prod;
  logic [CNT_W-1:0]   w_dly_load;
  logic               w_tmr_load;
  logic               w_tmr_en;
  logic               w_tmr_zero;

  assign w_lut_addr = lut_data_i[ADDR_W+DATA_W-1:DATA_W];
  assign w_lut_data = lut_data_i[DATA_W-1:0];
  assign w_is_read  = (idx_q < READ_LIMIT);
  assign w_dly_prod = CNT_W'(w_lut_data) * CNT_W'(DELAY_UNIT);
  // The timer exits on zero, so N delay cycles need N-1 loaded; 0 still costs one cycle.
  assign w_dly_load = (w_dly_prod == '0) ? '0 : (w_dly_prod - CNT_W'(1));

  cfg_delay_timer #(
    .CNT_W (CNT_W)
  ) u_delay_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_tmr_load),
    .load_val_i (w_dly_load),
    .en_i       (w_tmr_en),
    .zero_o     (w_tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    entry_d     = entry_q;
    retry_d     = retry_q;
    err_code_d  = err_code_q;
    err_index_d = err_index_q;
    w_tmr_load  = 1'b0;
    w_tmr_en    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          retry_d = '0;
          if (lut_size_i == '0) begin
            state_d     = S_FAIL;
            err_code_d  = ERR_EMPTY;
            err_index_d = '0;
          end else begin
            state_d    = S_FETCH;
            idx_d      = '0;
            err_code_d = ERR_NONE;
          end
        end
      end
      S_FETCH: begin
        entry_d = w_lut_data;
        if ((w_lut_addr == DELAY_TAG) && !w_is_read) begin
          state_d    = S_DELAY;
          w_tmr_load = 1'b1;
        end else begin
          state_d = S_ISSUE;
          rw_d    = w_is_read;
          addr_d  = w_lut_addr;
          wdata_d = w_is_read ? '0 : w_lut_data;
        end
      end
      S_ISSUE: begin
        if (bus.cmd_ready) state_d = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (bus.rsp_valid) begin
          if (bus.rsp_nack) begin
            if (retry_q < RETRY_LIMIT) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = S_ISSUE;
            end else begin
              state_d     = S_FAIL;
              err_code_d  = ERR_NACK;
              err_index_d = idx_q;
            end
          end else if (rw_q && (bus.rsp_rdata != entry_q)) begin
            state_d     = S_FAIL;
            err_code_d  = ERR_MISMATCH;
            err_index_d = idx_q;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_DELAY: begin
        w_tmr_en = 1'b1;
        if (w_tmr_zero) state_d = S_NEXT;
      end
      S_NEXT: begin
        retry_d = '0;
        if (idx_q == (lut_size_i - IDX_W'(1))) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      entry_q     <= '0;
      retry_q     <= '0;
      err_code_q  <= ERR_NONE;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      entry_q     <= entry_d;
      retry_q     <= retry_d;
      err_code_q  <= err_code_d;
      err_index_q <= err_index_d;
    end
  end

  // Status and cmd_valid decode straight from state so reset clears them asynchronously.
  assign bus.cmd_valid = (state_q == S_ISSUE);
  assign bus.cmd_rw    = rw_q;
  assign bus.cmd_addr  = addr_q;
  assign bus.cmd_wdata = wdata_q;
  assign lut_index_o   = idx_q;
  assign busy_o        = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
  assign done_o        = (state_q == S_DONE);
  assign error_o       = (state_q == S_FAIL);
  assign err_code_o    = err_code_q;
  assign err_index_o   = err_index_q;

endmodule

`default_nettype wire

// File: tb/tb_cmos_cfg_sequencer.sv
// tb_cmos_cfg_sequencer: directed scoreboard bench with a behavioural SCCB bus master model.
// Revision 1.0
`default_nettype none

module tb_cmos_cfg_sequencer;
  import cmos_cfg_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int IW = 8;
  localparam int DU = 10;
  localparam logic [24:0] NO_CMD = 25'h1FF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0]    lut_index, lut_size, err_index;
  logic [AW+DW-1:0] lut_data;
  logic             busy, done, error;
  logic [1:0]       err_code;
  logic [AW+DW-1:0] lut_mem [256];
  logic [DW-1:0]    rd_val  [256];

  assign lut_data = lut_mem[lut_index];

  cmos_cfg_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  cmos_cfg_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .IDX_W(IW), .READ_CNT(2),
    .DELAY_TAG(8'hF0), .DELAY_UNIT(DU), .MAX_RETRY(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .lut_index_o (lut_index),
    .lut_data_i  (lut_data),
    .lut_size_i  (lut_size),
    .bus         (bus_if),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .err_code_o  (err_code),
    .err_index_o (err_index)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [24:0] exp_q[$];
  int rdy_dly = 2, rsp_dly = 2, rdy_wait = 2;
  int fire_cnt = 0, rsp_cnt = 0, nack_left = 0;
  logic [AW-1:0] nack_addr = 8'h0C;
  logic [DW-1:0] nack_data = 16'h0001;

  function automatic void check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic rw, input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back({rw, a, d});
  endtask

  task automatic push_reads();
    push(1'b1, 8'hFE, 16'h0000);
    push(1'b1, 8'h00, 16'h0000);
  endtask

  task automatic push_std();
    push_reads();
    push(1'b0, 8'h0C, 16'h0001);
    push(1'b0, 8'h0C, 16'h0000);
    push(1'b0, 8'h0D, 16'h0330);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      tick();
      n++;
    end
    check("finished", 32'(done || error), 32'd1);
  endtask

  task automatic prep(input int rdly, input int sdly);
    fire_cnt = 0;
    rsp_cnt  = 0;
    rdy_dly  = rdly;
    rdy_wait = rdly;
    rsp_dly  = sdly;
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_lut_index"}, 32'(lut_index), 32'd0);
    check({tag, "_cmd_valid"}, 32'(bus_if.cmd_valid), 32'd0);
    check({tag, "_cmd_rw"}, 32'(bus_if.cmd_rw), 32'd0);
    check({tag, "_cmd_addr"}, 32'(bus_if.cmd_addr), 32'd0);
    check({tag, "_cmd_wdata"}, 32'(bus_if.cmd_wdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
    check({tag, "_err_index"}, 32'(err_index), 32'd0);
  endtask

  // Bus master model: drives on negedges; a command fires at the posedge after valid&&ready is seen.
  initial begin
    logic [24:0] got, expv;
    logic        pend, pend_nack;
    logic [15:0] pend_data;
    int          pend_wait;
    pend = 1'b0; pend_nack = 1'b0; pend_data = '0; pend_wait = 0;
    bus_if.cmd_ready = 1'b0;
    bus_if.rsp_valid = 1'b0;
    bus_if.rsp_nack  = 1'b0;
    bus_if.rsp_rdata = '0;
    forever begin
      @(negedge clk);
      bus_if.rsp_valid = 1'b0;
      bus_if.rsp_nack  = 1'b0;
      bus_if.rsp_rdata = '0;
      if (pend) begin
        if (pend_wait == 0) begin
          bus_if.rsp_valid = 1'b1;
          bus_if.rsp_nack  = pend_nack;
          bus_if.rsp_rdata = pend_data;
          pend = 1'b0;
          rsp_cnt++;
        end else begin
          pend_wait--;
        end
      end
      if (bus_if.cmd_valid && !rst) begin
        if (rdy_wait == 0) begin
          bus_if.cmd_ready = 1'b1;
        end else begin
          bus_if.cmd_ready = 1'b0;
          rdy_wait--;
        end
      end else begin
        bus_if.cmd_ready = 1'b0;
      end
      if (bus_if.cmd_valid && bus_if.cmd_ready) begin
        got  = {bus_if.cmd_rw, bus_if.cmd_addr, bus_if.cmd_wdata};
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : NO_CMD;
        check("cmd", 32'(got), 32'(expv));
        fire_cnt++;
        rdy_wait  = rdy_dly;
        pend      = 1'b1;
        pend_wait = rsp_dly;
        pend_nack = !bus_if.cmd_rw && (nack_left > 0) &&
                    (bus_if.cmd_addr == nack_addr) && (bus_if.cmd_wdata == nack_data);
        if (pend_nack) nack_left--;
        pend_data = bus_if.cmd_rw ? rd_val[bus_if.cmd_addr] : 16'h0000;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      lut_mem[i] = '0;
      rd_val[i]  = '0;
    end
    lut_mem[0] = {8'hFE, 16'hBEEF};
    lut_mem[1] = {8'h00, 16'h1313};
    lut_mem[2] = {8'h0C, 16'h0001};
    lut_mem[3] = {8'h0C, 16'h0000};
    lut_mem[4] = {8'h0D, 16'h0330};
    rd_val[8'hFE] = 16'hBEEF;
    rd_val[8'h00] = 16'h1313;
    lut_size = 8'd5;

    repeat (2) tick();
    check_reset_vals("rst");
    rst = 1'b0;
    tick();

    // Test 1: happy path, 2 reads then 3 writes
    prep(2, 2);
    push_std();
    pulse_start();
    wait_end(500);
    check("t1_done", 32'(done), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_fires", 32'(fire_cnt), 32'd5);
    check("t1_queue", 32'(exp_q.size()), 32'd0);

    // Test 2: read mismatch on entry 1, no write may follow
    rd_val[8'h00] = 16'h1324;
    prep(2, 2);
    push_reads();
    pulse_start();
    wait_end(500);
    repeat (10) tick();
    check("t2_error", 32'(error), 32'd1);
    check("t2_err_code", 32'(err_code), 32'(ERR_MISMATCH));
    check("t2_err_index", 32'(err_index), 32'd1);
    check("t2_done", 32'(done), 32'd0);
    check("t2_queue", 32'(exp_q.size()), 32'd0);
    rd_val[8'h00] = 16'h1313;

    // Test 3a: two NACKs on entry 2 are retried
    prep(1, 1);
    nack_left = 2;
    push_reads();
    repeat (3) push(1'b0, 8'h0C, 16'h0001);
    push(1'b0, 8'h0C, 16'h0000);
    push(1'b0, 8'h0D, 16'h0330);
    pulse_start();
    wait_end(500);
    check("t3a_done", 32'(done), 32'd1);
    check("t3a_err_code", 32'(err_code), 32'(ERR_NONE));
    check("t3a_fires", 32'(fire_cnt), 32'd7);
    check("t3a_queue", 32'(exp_q.size()), 32'd0);

    // Test 3b: MAX_RETRY+1 NACKs abort the sequence
    prep(1, 1);
    nack_left = 4;
    push_reads();
    repeat (4) push(1'b0, 8'h0C, 16'h0001);
    pulse_start();
    wait_end(500);
    repeat (10) tick();
    check("t3b_error", 32'(error), 32'd1);
    check("t3b_err_code", 32'(err_code), 32'(ERR_NACK));
    check("t3b_err_index", 32'(err_index), 32'd2);
    check("t3b_fires", 32'(fire_cnt), 32'd6);
    check("t3b_queue", 32'(exp_q.size()), 32'd0);
    nack_left = 0;

    // Test 4: delay entry {F0,0005} at index 3
    lut_mem[3] = {8'hF0, 16'h0005};
    prep(2, 2);
    push_reads();
    push(1'b0, 8'h0C, 16'h0001);
    push(1'b0, 8'h0D, 16'h0330);
    pulse_start();
    n = 0;
    while (rsp_cnt < 3 && n < 500) begin
      tick();
      n++;
    end
    check("t4_rsp_seen", 32'(rsp_cnt), 32'd3);
    n = 0;
    tick();
    while (!bus_if.cmd_valid && n < 300) begin
      n++;
      tick();
    end
    // Idle span = NEXT + FETCH + 5*DU DELAY cycles + NEXT + FETCH
    check("t4_gap", 32'(n), 32'(5 * DU + 4));
    wait_end(500);
    check("t4_done", 32'(done), 32'd1);
    check("t4_fires", 32'(fire_cnt), 32'd4);
    check("t4_queue", 32'(exp_q.size()), 32'd0);
    lut_mem[3] = {8'h0C, 16'h0000};

    // Test 5: backpressure for 7 cycles on the first command
    prep(0, 2);
    rdy_wait = 7;
    push_std();
    pulse_start();
    n = 0;
    while (!bus_if.cmd_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 7; i++) begin
      check("t5_hold", 32'({bus_if.cmd_valid, bus_if.cmd_ready, bus_if.cmd_rw,
                            bus_if.cmd_addr, bus_if.cmd_wdata}),
            32'({1'b1, 1'b0, 1'b1, 8'hFE, 16'h0000}));
      tick();
    end
    wait_end(500);
    check("t5_done", 32'(done), 32'd1);
    check("t5_fires", 32'(fire_cnt), 32'd5);
    check("t5_queue", 32'(exp_q.size()), 32'd0);

    // Test 6a: reset asserted while waiting for a response
    prep(0, 6);
    push_std();
    pulse_start();
    n = 0;
    while (fire_cnt < 1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    check("t6_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("t6_rst");
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_done", 32'(done), 32'd0);
    check("t6_idle_error", 32'(error), 32'd0);

    // Test 6b: clean restart with a start pulse while busy
    prep(2, 2);
    push_std();
    pulse_start();
    repeat (6) tick();
    pulse_start();
    wait_end(500);
    check("t6b_done", 32'(done), 32'd1);
    check("t6b_err_code", 32'(err_code), 32'(ERR_NONE));
    check("t6b_fires", 32'(fire_cnt), 32'd5);
    check("t6b_queue", 32'(exp_q.size()), 32'd0);

    // Test 6c: empty LUT
    prep(2, 2);
    lut_size = 8'd0;
    pulse_start();
    check("t6c_error", 32'(error), 32'd1);
    check("t6c_err_code", 32'(err_code), 32'(ERR_EMPTY));
    check("t6c_err_index", 32'(err_index), 32'd0);
    check("t6c_busy", 32'(busy), 32'd0);
    check("t6c_done", 32'(done), 32'd0);
    repeat (5) tick();
    check("t6c_fires", 32'(fire_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
